// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and helpers for the clock-divider sequencer (clk_div_ctrl).
package clk_div_ctrl_pkg;

  localparam int DIV_W = 33;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    APPLY,
    SETTLE,
    ACK,
    NACK
  } state_t;

  // Lowest-index set request at or after ptr, wrapping modulo n (n <= 8).
  function automatic logic [2:0] rr_next_grant(input logic [7:0] req,
                                               input logic [2:0] ptr,
                                               input int         n);
    logic found;
    int   k;
    rr_next_grant = ptr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if (i < n && !found && req[k[2:0]]) begin
        rr_next_grant = k[2:0];
        found = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Requester handshake bundle for clk_div_ctrl.
// Optional CLK_DIV_CTRL_LOCK_EN adds the lock request / nack pair.
interface clk_div_ctrl_if #(
  parameter int NUM_REQ = 2,
  parameter int DIV_W   = clk_div_ctrl_pkg::DIV_W
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*DIV_W-1:0] req_div;
  logic [NUM_REQ-1:0]       req_ack;
`ifdef CLK_DIV_CTRL_LOCK_EN
  logic [NUM_REQ-1:0]       req_lock;
  logic [NUM_REQ-1:0]       req_nack;

  modport master (output req_valid, req_div, req_lock, input req_ack, req_nack);
  modport slave  (input req_valid, req_div, req_lock, output req_ack, req_nack);
`else
  modport master (output req_valid, req_div, input req_ack);
  modport slave  (input req_valid, req_div, output req_ack);
`endif
endinterface

// File: rtl/clk_div_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant and index of the winner.
module rr_arbiter import clk_div_ctrl_pkg::*; #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  logic [7:0] req8;
  logic [2:0] pick;

  always_comb begin
    req8 = '0;
    req8[NUM_REQ-1:0] = req;
    pick  = rr_next_grant(req8, 3'(ptr), NUM_REQ);
    idx   = IDX_W'(pick);
    valid = |req;
    grant = '0;
    if (valid) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Round-robin sequencer that safely retunes a shared clock_divider divisor.
// Optional CLK_DIV_CTRL_LOCK_EN lets one requester lock out the others.
module clk_div_ctrl import clk_div_ctrl_pkg::*; #(
  parameter  int              NUM_REQ     = 2,
  parameter  int              DIV_W       = clk_div_ctrl_pkg::DIV_W,
  parameter  longint unsigned DEFAULT_DIV = 1,
  parameter  longint unsigned MIN_DIV     = 1,
  parameter  int              SETTLE_CYC  = 4,
  parameter  int              TIMEOUT_CYC = 1024,
  localparam int              IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_in,
  input  logic               reset,
  clk_div_ctrl_if.slave      req_bus,
  input  logic               div_fb,
  output logic [DIV_W-1:0]   clk_div,
  output logic               div_rst_n,
  output logic               busy,
  output logic [IDX_W-1:0]   owner,
  output logic               timeout_err
);

  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [DIV_W-1:0] DEF_D   = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_D   = DIV_W'(MIN_DIV);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(SETTLE_CYC - 1);

  state_t             state;
  logic               fb_meta, fb_s;
  logic [IDX_W-1:0]   ptr, ptr_next;
  logic [DIV_W-1:0]   lat_div, gnt_raw, gnt_div;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] ack_q, gnt_vec;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any, nack_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_bus.req_valid),
    .ptr   (ptr),
    .grant (gnt_vec),
    .idx   (gnt_idx),
    .valid (gnt_any)
  );

  always_comb begin
    gnt_raw = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_vec[i]) gnt_raw |= req_bus.req_div[i*DIV_W +: DIV_W];
    gnt_div  = (gnt_raw < MIN_D) ? MIN_D : gnt_raw;
    ptr_next = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end

  // div_fb comes from the divided clock, so it is resynchronised before use.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      fb_meta <= 1'b0;
      fb_s    <= 1'b0;
    end else begin
      fb_meta <= div_fb;
      fb_s    <= fb_meta;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      lat_div     <= DEF_D;
      cnt         <= '0;
      clk_div     <= DEF_D;
      div_rst_n   <= 1'b0;
      ack_q       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      div_rst_n <= 1'b1;
      ack_q     <= '0;
      case (state)
        IDLE: if (gnt_any) begin
          owner   <= gnt_idx;
          ptr     <= ptr_next;
          lat_div <= gnt_div;
          busy    <= 1'b1;
          if (nack_hit) begin
            state <= NACK;
          end else if (gnt_div == clk_div) begin
            state <= ACK;
            ack_q <= gnt_vec;
          end else begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
        end
        WAIT_LOW: begin
          if (!fb_s) begin
            state <= APPLY;
          end else if (cnt == TO_LAST) begin
            state       <= APPLY;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        APPLY: begin
          clk_div   <= lat_div;
          div_rst_n <= 1'b0;
          cnt       <= '0;
          state     <= SETTLE;
        end
        SETTLE: begin
          if (cnt == ST_LAST) begin
            state        <= ACK;
            ack_q[owner] <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACK, NACK: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_bus.req_ack = ack_q;

`ifdef CLK_DIV_CTRL_LOCK_EN
  logic               lock_on;
  logic [IDX_W-1:0]   lock_holder;
  logic [NUM_REQ-1:0] nack_q;

  assign nack_hit = lock_on && (gnt_idx != lock_holder);

  // Lock ownership only changes on a grant that is actually honoured.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      lock_on     <= 1'b0;
      lock_holder <= '0;
      nack_q      <= '0;
    end else begin
      nack_q <= '0;
      if (state == IDLE && gnt_any) begin
        if (nack_hit) begin
          nack_q <= gnt_vec;
        end else if (req_bus.req_lock[gnt_idx]) begin
          lock_on     <= 1'b1;
          lock_holder <= gnt_idx;
        end else if (lock_on && lock_holder == gnt_idx) begin
          lock_on <= 1'b0;
        end
      end
    end
  end

  assign req_bus.req_nack = nack_q;
`else
  assign nack_hit = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: acks are matched in predicted round-robin order.
module tb_clk_div_ctrl;
  import clk_div_ctrl_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DW      = DIV_W;

  typedef struct {
    int            idx;
    logic [DW-1:0] div;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          reset  = 1'b0;
  logic          div_fb = 1'b0;
  logic [DW-1:0] clk_div;
  logic          div_rst_n, busy, timeout_err;
  logic [0:0]    owner;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  int            rst_lows = 0;
  int            m_ptr = 0;
  exp_t          mon_e;
  logic [1:0]    mon_oh;

  clk_div_ctrl_if #(.NUM_REQ(NUM_REQ)) bus ();

  clk_div_ctrl #(
    .NUM_REQ     (NUM_REQ),
    .DEFAULT_DIV (1),
    .MIN_DIV     (2),
    .SETTLE_CYC  (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .req_bus     (bus),
    .div_fb      (div_fb),
    .clk_div     (clk_div),
    .div_rst_n   (div_rst_n),
    .busy        (busy),
    .owner       (owner),
    .timeout_err (timeout_err)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [1:0] m, input int p);
    if (m[p]) return p;
    if (m[1-p]) return 1 - p;
    return -1;
  endfunction

  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] d);
    return (d < 2) ? DW'(2) : d;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Drives a request set; expected acks are queued in round-robin order.
  task automatic applyStimulus(input logic [1:0] mask, input logic [DW-1:0] d0,
                               input logic [DW-1:0] d1, input bit expect_ack);
    logic [1:0] m;
    int         k;
    exp_t       e;
    bus.req_div   = {d1, d0};
    bus.req_valid = bus.req_valid | mask;
    m = mask;
    while (expect_ack && m != 2'b00) begin
      k     = model_pick(m, m_ptr);
      e.idx = k;
      e.div = clamp(k == 1 ? d1 : d0);
      sb.push_back(e);
      m[k]  = 1'b0;
      m_ptr = (k + 1) % 2;
    end
  endtask

  task automatic wait_ack(inout int lat, input int limit);
    bit done = 1'b0;
    while (!done && lat < limit) begin
      step();
      lat++;
      if (bus.req_ack != '0) begin
        bus.req_valid = bus.req_valid & ~bus.req_ack;
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      step();
      n++;
      if (bus.req_ack != '0) bus.req_valid = bus.req_valid & ~bus.req_ack;
    end
  endtask

  always @(negedge clk_in) begin
    if (reset && !div_rst_n) rst_lows++;
    if (bus.req_ack != '0) begin
      if (sb.size() == 0) begin
        checkOutput("ack_unexpected", bus.req_ack, 0);
      end else begin
        mon_e  = sb.pop_front();
        mon_oh = '0;
        mon_oh[mon_e.idx] = 1'b1;
        checkOutput("ack_vec", bus.req_ack, mon_oh);
        checkOutput("ack_div", clk_div, mon_e.div);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, r0;
    bus.req_valid = '0;
    bus.req_div   = '0;
`ifdef CLK_DIV_CTRL_LOCK_EN
    bus.req_lock  = '0;
`endif
    repeat (3) step();
    checkOutput("rst_clk_div", clk_div, 1);
    checkOutput("rst_div_rst_n", div_rst_n, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_owner", owner, 0);
    checkOutput("rst_ack", bus.req_ack, 0);
    reset = 1'b1;
    #1 checkOutput("rel_div_rst_n_low", div_rst_n, 0);
    step();
    checkOutput("rel_div_rst_n_high", div_rst_n, 1);
    checkOutput("rel_busy", busy, 0);
    step();
    step();

    $display("[TB] single change, fb low");
    r0 = rst_lows;
    applyStimulus(2'b01, 10, 0, 1);
    step(); checkOutput("s_busy", busy, 1);
    step(); checkOutput("s_div_before", clk_div, 1);
    step(); checkOutput("s_div_applied", clk_div, 10);
    checkOutput("s_rst_pulse", div_rst_n, 0);
    step(); checkOutput("s_rst_release", div_rst_n, 1);
    lat = 4;
    wait_ack(lat, 40);
    checkOutput("s_ack_lat", lat, 7);
    step(); checkOutput("s_idle", busy, 0);
    checkOutput("s_rst_pulses", rst_lows - r0, 1);

    $display("[TB] apply waits for fb low");
    div_fb = 1'b1;
    repeat (3) step();
    applyStimulus(2'b10, 0, 5, 1);
    repeat (10) step();
    checkOutput("w_div_held", clk_div, 10);
    checkOutput("w_busy", busy, 1);
    checkOutput("w_owner", owner, 1);
    div_fb = 1'b0;
    repeat (3) step();
    checkOutput("w_div_q3", clk_div, 10);
    step();
    checkOutput("w_div_q4", clk_div, 5);
    lat = 4;
    wait_ack(lat, 40);
    checkOutput("w_ack_lat", lat, 8);
    checkOutput("w_no_timeout", timeout_err, 0);
    step();

    $display("[TB] round-robin arbitration");
    applyStimulus(2'b11, 7, 9, 1);
    wait_drain(200);
    checkOutput("arb1_drain", sb.size(), 0);
    step();
    applyStimulus(2'b01, 4, 0, 1);
    wait_drain(100);
    step();
    applyStimulus(2'b11, 3, 6, 1);
    wait_drain(200);
    checkOutput("arb2_drain", sb.size(), 0);
    checkOutput("arb2_owner", owner, 0);
    step();

    $display("[TB] clamp and no-op");
    applyStimulus(2'b01, 0, 0, 1);
    wait_drain(100);
    checkOutput("c_clamped", clk_div, 2);
    step();
    r0 = rst_lows;
    applyStimulus(2'b01, 2, 0, 1);
    lat = 0;
    wait_ack(lat, 20);
    checkOutput("n_ack_lat", lat, 1);
    step();
    step();
    checkOutput("n_no_rst_pulse", rst_lows - r0, 0);
    checkOutput("n_div", clk_div, 2);

    $display("[TB] timeout forced apply");
    div_fb = 1'b1;
    repeat (3) step();
    applyStimulus(2'b10, 0, 12, 1);
    repeat (16) step();
    checkOutput("t_err_before", timeout_err, 0);
    step();
    checkOutput("t_err_set", timeout_err, 1);
    checkOutput("t_div_before", clk_div, 2);
    step();
    checkOutput("t_div_applied", clk_div, 12);
    lat = 18;
    wait_ack(lat, 60);
    checkOutput("t_ack_lat", lat, 22);
    step();

    $display("[TB] reset during settle");
    div_fb = 1'b0;
    repeat (3) step();
    applyStimulus(2'b01, 20, 0, 0);
    repeat (3) step();
    checkOutput("m_div_applied", clk_div, 20);
    step();
    checkOutput("m_busy", busy, 1);
    reset = 1'b0;
    bus.req_valid = '0;
    #1;
    checkOutput("m_clk_div", clk_div, 1);
    checkOutput("m_timeout_err", timeout_err, 0);
    checkOutput("m_busy_rst", busy, 0);
    checkOutput("m_div_rst_n", div_rst_n, 0);
    checkOutput("m_owner", owner, 0);
    repeat (2) step();
    reset = 1'b1;
    repeat (12) step();
    checkOutput("m_idle", busy, 0);
    checkOutput("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
